// File: rtl/core_brk_seq.sv
// core_brk_seq: interrupt-entry microsequencer for the 2A03 core.
// After the opcode fetch of BRK/IRQ/NMI/RESET, this block runs the six-cycle tail:
//   dummy read, push PCH/PCL/P, fetch vector low/high.
// It then pulses O_pc_load so the core loads O_pc and sets the I flag.
// While the sequence runs, this block drives the core bus.
//
// Optional feature macro: BRK_NMI_HIJACK_EN
//   defined   - vector addresses are sampled on entry to VEC_LO, so an NMI raised
//               during the pushes can redirect a BRK/IRQ to the NMI vector.
//   undefined - vector addresses are latched together with I_start.
//
// Ports:
//   I_clock, I_reset          clock, synchronous active-high reset
//   I_enable                  CPU cycle strobe; state advances only when high
//   I_start                   begin sequence (sampled in IDLE)
//   I_force_brk, I_res        hardware entry / RESET entry (stack cycles become reads)
//   I_vec_addr_lo/hi          vector byte addresses
//   I_pc, I_sp, I_p           PC after opcode fetch, stack pointer, status at start
//   I_data                    bus read data
//   O_addr, O_data, O_rw      bus address, write data, 1 = read
//   O_busy, O_sp              sequence in progress, running stack pointer
//   O_pc, O_pc_load           new PC and its one-enabled-cycle load pulse
module core_brk_seq #(
  parameter logic [7:0] STACK_PAGE = 8'h01,
  parameter logic [7:0] P_ONE_MASK = 8'h20
) (
  input  logic        I_clock,
  input  logic        I_reset,
  input  logic        I_enable,
  input  logic        I_start,
  input  logic        I_force_brk,
  input  logic        I_res,
  input  logic [15:0] I_vec_addr_lo,
  input  logic [15:0] I_vec_addr_hi,
  input  logic [15:0] I_pc,
  input  logic [7:0]  I_sp,
  input  logic [7:0]  I_p,
  input  logic [7:0]  I_data,
  output logic [15:0] O_addr,
  output logic [7:0]  O_data,
  output logic        O_rw,
  output logic        O_busy,
  output logic [7:0]  O_sp,
  output logic [15:0] O_pc,
  output logic        O_pc_load
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] DUMMY  = 3'd1;
  localparam logic [2:0] PUSH_H = 3'd2;
  localparam logic [2:0] PUSH_L = 3'd3;
  localparam logic [2:0] PUSH_P = 3'd4;
  localparam logic [2:0] VEC_LO = 3'd5;
  localparam logic [2:0] VEC_HI = 3'd6;

  logic [2:0]  state;
  logic [15:0] ret_addr;
  logic [7:0]  stat;
  logic        res_entry;
  logic        b_flag;
  logic [15:0] vec_hi;
  logic [7:0]  pc_lo;
`ifndef BRK_NMI_HIJACK_EN
  logic [15:0] vec_lo;
`endif

  // Software BRK skips its signature byte, so the return address is PC+1.
  logic [15:0] ret_next;
  assign ret_next = I_force_brk ? I_pc : I_pc + 16'd1;

  always_ff @(posedge I_clock) begin
    if (I_reset) begin
      state     <= IDLE;
      ret_addr  <= 16'h0000;
      stat      <= 8'h00;
      res_entry <= 1'b0;
      b_flag    <= 1'b0;
      vec_hi    <= 16'h0000;
      pc_lo     <= 8'h00;
`ifndef BRK_NMI_HIJACK_EN
      vec_lo    <= 16'h0000;
`endif
      O_addr    <= 16'h0000;
      O_data    <= 8'h00;
      O_rw      <= 1'b1;
      O_busy    <= 1'b0;
      O_sp      <= 8'h00;
      O_pc      <= 16'h0000;
      O_pc_load <= 1'b0;
    end else if (I_enable) begin
      O_pc_load <= 1'b0;
      case (state)
        IDLE: begin
          if (I_start) begin
            ret_addr  <= ret_next;
            O_sp      <= I_sp;
            stat      <= I_p;
            res_entry <= I_res;
            b_flag    <= ~I_force_brk;
`ifndef BRK_NMI_HIJACK_EN
            vec_lo    <= I_vec_addr_lo;
            vec_hi    <= I_vec_addr_hi;
`endif
            O_addr    <= ret_next;
            O_data    <= 8'h00;
            O_rw      <= 1'b1;
            O_busy    <= 1'b1;
            state     <= DUMMY;
          end
        end
        DUMMY: begin
          O_addr <= {STACK_PAGE, O_sp};
          O_data <= ret_addr[15:8];
          O_rw   <= res_entry;
          O_sp   <= O_sp - 8'd1;
          state  <= PUSH_H;
        end
        PUSH_H: begin
          O_addr <= {STACK_PAGE, O_sp};
          O_data <= ret_addr[7:0];
          O_rw   <= res_entry;
          O_sp   <= O_sp - 8'd1;
          state  <= PUSH_L;
        end
        PUSH_L: begin
          O_addr <= {STACK_PAGE, O_sp};
          O_data <= stat | P_ONE_MASK | {3'b000, b_flag, 4'b0000};
          O_rw   <= res_entry;
          O_sp   <= O_sp - 8'd1;
          state  <= PUSH_P;
        end
        PUSH_P: begin
`ifdef BRK_NMI_HIJACK_EN
          // Late sampling lets an NMI that arrived during the pushes take the vector.
          O_addr <= I_vec_addr_lo;
          vec_hi <= I_vec_addr_hi;
`else
          O_addr <= vec_lo;
`endif
          O_data <= 8'h00;
          O_rw   <= 1'b1;
          state  <= VEC_LO;
        end
        VEC_LO: begin
          pc_lo  <= I_data;
          O_addr <= vec_hi;
          O_rw   <= 1'b1;
          state  <= VEC_HI;
        end
        VEC_HI: begin
          O_pc      <= {I_data, pc_lo};
          O_pc_load <= 1'b1;
          O_addr    <= 16'h0000;
          O_data    <= 8'h00;
          O_rw      <= 1'b1;
          O_busy    <= 1'b0;
          state     <= IDLE;
        end
        default: begin
          O_busy <= 1'b0;
          O_rw   <= 1'b1;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_core_brk_seq.sv
// tb_core_brk_seq: table-driven bench for core_brk_seq.
// Each entry-sequence record produces an expected bus trace that is pushed to a scoreboard
// queue. The trace is popped and compared cycle by cycle.
// Hand-written sequences cover reset values and a reset arriving mid-sequence.
module tb_core_brk_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        start;
  logic        fb;
  logic        res;
  logic [15:0] vlo;
  logic [15:0] vhi;
  logic [15:0] pc_in;
  logic [7:0]  sp_in;
  logic [7:0]  p_in;
  logic [7:0]  rdata;
  logic [15:0] addr;
  logic [7:0]  wdata;
  logic        rw;
  logic        busy;
  logic [7:0]  sp_out;
  logic [15:0] pc_out;
  logic        pc_load;

  core_brk_seq dut (
    .I_clock      (clk),
    .I_reset      (rst),
    .I_enable     (en),
    .I_start      (start),
    .I_force_brk  (fb),
    .I_res        (res),
    .I_vec_addr_lo(vlo),
    .I_vec_addr_hi(vhi),
    .I_pc         (pc_in),
    .I_sp         (sp_in),
    .I_p          (p_in),
    .I_data       (rdata),
    .O_addr       (addr),
    .O_data       (wdata),
    .O_rw         (rw),
    .O_busy       (busy),
    .O_sp         (sp_out),
    .O_pc         (pc_out),
    .O_pc_load    (pc_load)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] mem_rd(input logic [15:0] a);
    case (a)
      16'hFFFA: mem_rd = 8'h78;
      16'hFFFB: mem_rd = 8'h56;
      16'hFFFC: mem_rd = 8'h00;
      16'hFFFD: mem_rd = 8'hF0;
      16'hFFFE: mem_rd = 8'h34;
      16'hFFFF: mem_rd = 8'h12;
      default:  mem_rd = 8'hEA;
    endcase
  endfunction

  always_comb rdata = mem_rd(addr);

  typedef struct {
    logic        fb;
    logic        res;
    logic [15:0] pc;
    logic [7:0]  sp;
    logic [7:0]  p;
    logic [15:0] vlo;
    logic [15:0] vhi;
    logic        stretch;
    logic        hijack;
    logic [15:0] exp_pc;
    logic [7:0]  exp_sp;
  } vec_t;

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  data;
    logic        rw;
  } bus_t;

  vec_t vecs[6];
  bus_t sb[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_bus(input bus_t e, input string tag);
    chk({tag, " addr"}, {16'h0, addr}, {16'h0, e.addr});
    chk({tag, " rw"}, {31'h0, rw}, {31'h0, e.rw});
    chk({tag, " busy"}, {31'h0, busy}, 32'h1);
    if (!e.rw) chk({tag, " wdata"}, {24'h0, wdata}, {24'h0, e.data});
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    logic [15:0] ret;
    logic [15:0] vlo_e;
    logic [15:0] vhi_e;
    logic [15:0] exp_pc;
    bus_t        e;
    string       tag;
    ret   = v.fb ? v.pc : v.pc + 16'd1;
    vlo_e = v.vlo;
    vhi_e = v.vhi;
`ifdef BRK_NMI_HIJACK_EN
    if (v.hijack) begin
      vlo_e = 16'hFFFA;
      vhi_e = 16'hFFFB;
    end
`endif
    exp_pc = v.hijack ? {mem_rd(vhi_e), mem_rd(vlo_e)} : v.exp_pc;

    fb = v.fb; res = v.res; pc_in = v.pc; sp_in = v.sp; p_in = v.p;
    vlo = v.vlo; vhi = v.vhi;
    en = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    sb.push_back('{addr: ret, data: 8'h00, rw: 1'b1});
    sb.push_back('{addr: {8'h01, v.sp}, data: ret[15:8], rw: v.res});
    sb.push_back('{addr: {8'h01, v.sp - 8'd1}, data: ret[7:0], rw: v.res});
    sb.push_back('{addr: {8'h01, v.sp - 8'd2}, data: v.p | 8'h20 | (v.fb ? 8'h00 : 8'h10),
                   rw: v.res});
    sb.push_back('{addr: vlo_e, data: 8'h00, rw: 1'b1});
    sb.push_back('{addr: vhi_e, data: 8'h00, rw: 1'b1});

    for (int k = 0; k < 6; k++) begin
      e = sb.pop_front();
      tag = $sformatf("v%0d c%0d", idx, k);
      check_bus(e, tag);
      if (k == 2) start = 1'b1;  // must be ignored while busy
      if (v.hijack && k == 3) begin
        vlo = 16'hFFFA;
        vhi = 16'hFFFB;
      end
      if (v.stretch) begin
        en = 1'b0;
        tick();
        check_bus(e, {tag, " frz1"});
        tick();
        check_bus(e, {tag, " frz2"});
        en = 1'b1;
      end
      tick();
      start = 1'b0;
    end

    tag = $sformatf("v%0d", idx);
    chk({tag, " pc_load"}, {31'h0, pc_load}, 32'h1);
    chk({tag, " pc"}, {16'h0, pc_out}, {16'h0, exp_pc});
    chk({tag, " sp"}, {24'h0, sp_out}, {24'h0, v.exp_sp});
    chk({tag, " busy end"}, {31'h0, busy}, 32'h0);
    chk({tag, " rw end"}, {31'h0, rw}, 32'h1);
    if (v.stretch) begin
      en = 1'b0;
      tick();
      chk({tag, " pc_load frz"}, {31'h0, pc_load}, 32'h1);
      en = 1'b1;
    end
    tick();
    chk({tag, " pc_load drop"}, {31'h0, pc_load}, 32'h0);
    chk({tag, " idle busy"}, {31'h0, busy}, 32'h0);
  endtask

  initial begin
    //          fb    res   pc        sp     p      vlo       vhi       str   hij   exp_pc    sp
    vecs[0] = '{1'b0, 1'b0, 16'hC001, 8'hFD, 8'h04, 16'hFFFE, 16'hFFFF, 1'b0, 1'b0, 16'h1234, 8'hFA};
    vecs[1] = '{1'b1, 1'b0, 16'h8000, 8'hFD, 8'h00, 16'hFFFE, 16'hFFFF, 1'b0, 1'b0, 16'h1234, 8'hFA};
    vecs[2] = '{1'b1, 1'b1, 16'h1234, 8'h00, 8'h00, 16'hFFFC, 16'hFFFD, 1'b0, 1'b0, 16'hF000, 8'hFD};
    vecs[3] = '{1'b0, 1'b0, 16'hC001, 8'hFD, 8'h04, 16'hFFFE, 16'hFFFF, 1'b1, 1'b0, 16'h1234, 8'hFA};
    vecs[4] = '{1'b0, 1'b0, 16'hC001, 8'hFD, 8'h04, 16'hFFFE, 16'hFFFF, 1'b0, 1'b1, 16'h1234, 8'hFA};
    vecs[5] = '{1'b0, 1'b0, 16'hFFFF, 8'h01, 8'hC3, 16'hFFFE, 16'hFFFF, 1'b0, 1'b0, 16'h1234, 8'hFE};

    rst = 1'b1; en = 1'b0; start = 1'b0; fb = 1'b0; res = 1'b0;
    vlo = 16'hFFFE; vhi = 16'hFFFF; pc_in = 16'h0; sp_in = 8'h0; p_in = 8'h0;
    tick();
    tick();
    chk("rst addr", {16'h0, addr}, 32'h0);
    chk("rst data", {24'h0, wdata}, 32'h0);
    chk("rst rw", {31'h0, rw}, 32'h1);
    chk("rst busy", {31'h0, busy}, 32'h0);
    chk("rst sp", {24'h0, sp_out}, 32'h0);
    chk("rst pc", {16'h0, pc_out}, 32'h0);
    chk("rst pc_load", {31'h0, pc_load}, 32'h0);
    rst = 1'b0;
    en = 1'b1;
    tick();
    chk("idle busy", {31'h0, busy}, 32'h0);

    for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

    // Reset arriving while the PCL push is on the bus.
    fb = 1'b0; res = 1'b0; pc_in = 16'hC001; sp_in = 8'hFD; p_in = 8'h04;
    vlo = 16'hFFFE; vhi = 16'hFFFF;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    chk("mid PUSH_L addr", {16'h0, addr}, 32'h01FC);
    chk("mid PUSH_L rw", {31'h0, rw}, 32'h0);
    rst = 1'b1;
    tick();
    chk("mid rst busy", {31'h0, busy}, 32'h0);
    chk("mid rst rw", {31'h0, rw}, 32'h1);
    chk("mid rst addr", {16'h0, addr}, 32'h0);
    chk("mid rst pc_load", {31'h0, pc_load}, 32'h0);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("post rst pc_load", {31'h0, pc_load}, 32'h0);
      chk("post rst busy", {31'h0, busy}, 32'h0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
